// File: rtl/riscv_praterv_arbiter.sv
// Two-master to one-slave data memory arbiter with grant lock, round-robin or
// fixed priority, and an in-order ID FIFO that steers responses back.
module riscv_praterv_arbiter #(
  parameter int RR_EN       = 1,
  parameter int OUTST_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        slv_req_o,
  output logic [31:0] slv_addr_o,
  output logic        slv_we_o,
  output logic [3:0]  slv_be_o,
  output logic [31:0] slv_wdata_o,
  input  logic        slv_gnt_i,
  input  logic        slv_rvalid_i,
  input  logic [31:0] slv_rdata_i,
  input  logic        slv_err_i,
  output logic        proto_err_o,
  output logic        busy_o
);

  localparam logic [2:0] DEPTH_C   = 3'(OUTST_DEPTH);
  localparam logic [1:0] PTR_MAX_C = 2'(OUTST_DEPTH - 1);

  logic [3:0] fifo_r;
  logic [1:0] wr_ptr_r;
  logic [1:0] rd_ptr_r;
  logic [2:0] count_r;
  logic       lock_r;
  logic       lock_id_r;
  logic       last_r;
  logic       proto_err_r;

  logic       sel_s;
  logic       sel_req_s;
  logic       can_accept_s;
  logic       req_s;
  logic       hs_s;
  logic       pop_s;
  logic       head_s;

  // Master selection: lock wins, then priority scheme; m0 while in reset.
  always_comb begin
    sel_s = 1'b0;
    if (!rst_n) begin
      sel_s = 1'b0;
    end else if (lock_r) begin
      sel_s = lock_id_r;
    end else if (m0_req_i && m1_req_i) begin
      sel_s = (RR_EN != 0) ? ~last_r : 1'b0;
    end else if (m1_req_i) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  assign sel_req_s    = sel_s ? m1_req_i : m0_req_i;
  assign can_accept_s = (count_r < DEPTH_C) || ((count_r == DEPTH_C) && slv_rvalid_i);
  assign req_s        = rst_n & sel_req_s & can_accept_s;
  assign hs_s         = req_s & slv_gnt_i;
  assign pop_s        = rst_n & slv_rvalid_i & (count_r != 3'd0);
  assign head_s       = fifo_r[rd_ptr_r];

  assign slv_req_o   = req_s;
  assign slv_addr_o  = sel_s ? m1_addr_i  : m0_addr_i;
  assign slv_we_o    = sel_s ? m1_we_i    : m0_we_i;
  assign slv_be_o    = sel_s ? m1_be_i    : m0_be_i;
  assign slv_wdata_o = sel_s ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o    = hs_s & ~sel_s;
  assign m1_gnt_o    = hs_s &  sel_s;
  assign m0_rvalid_o = pop_s & ~head_s;
  assign m1_rvalid_o = pop_s &  head_s;
  assign m0_err_o    = pop_s & ~head_s & slv_err_i;
  assign m1_err_o    = pop_s &  head_s & slv_err_i;
  assign m0_rdata_o  = slv_rdata_i;
  assign m1_rdata_o  = slv_rdata_i;

  assign proto_err_o = proto_err_r;
  assign busy_o      = rst_n & ((count_r != 3'd0) | req_s);

  // ID FIFO storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_r   <= 4'd0;
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (hs_s) begin
        fifo_r[wr_ptr_r] <= sel_s;
        wr_ptr_r         <= (wr_ptr_r == PTR_MAX_C) ? 2'd0 : wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_MAX_C) ? 2'd0 : rd_ptr_r + 2'd1;
      end
      case ({hs_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Grant lock, round-robin pointer and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r      <= 1'b0;
      lock_id_r   <= 1'b0;
      last_r      <= 1'b1;
      proto_err_r <= 1'b0;
    end else begin
      if (hs_s) begin
        lock_r <= 1'b0;
        last_r <= sel_s;
      end else if (req_s) begin
        lock_r    <= 1'b1;
        lock_id_r <= sel_s;
      end else if (!sel_req_s) begin
        lock_r <= 1'b0;
      end else begin
        lock_r <= lock_r;
      end
      if (slv_rvalid_i && (count_r == 3'd0)) begin
        proto_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_praterv_arbiter.sv
// Randomized and directed bench for riscv_praterv_arbiter against a queue-based
// reference model; a second fixed-priority instance covers RR_EN=0.
module tb_riscv_praterv_arbiter;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        slv_req, slv_we, slv_gnt, slv_rvalid, slv_err, proto_err, busy;
  logic [31:0] slv_addr, slv_wdata, slv_rdata;
  logic [3:0]  slv_be;

  logic        f_m0_req, f_m1_req, f_gnt, f_rvalid;
  logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid, f_m0_err, f_m1_err;
  logic        f_slv_req, f_slv_we, f_proto_err, f_busy;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_slv_addr, f_slv_wdata;
  logic [3:0]  f_slv_be;

  riscv_praterv_arbiter #(.RR_EN(1), .OUTST_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .slv_req_o(slv_req), .slv_addr_o(slv_addr), .slv_we_o(slv_we), .slv_be_o(slv_be), .slv_wdata_o(slv_wdata),
    .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid), .slv_rdata_i(slv_rdata), .slv_err_i(slv_err),
    .proto_err_o(proto_err), .busy_o(busy)
  );

  riscv_praterv_arbiter #(.RR_EN(0), .OUTST_DEPTH(DEPTH)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(f_m0_req), .m0_addr_i(32'h0000_1000), .m0_we_i(1'b0), .m0_be_i(4'hF), .m0_wdata_i(32'd0),
    .m0_gnt_o(f_m0_gnt), .m0_rvalid_o(f_m0_rvalid), .m0_rdata_o(f_m0_rdata), .m0_err_o(f_m0_err),
    .m1_req_i(f_m1_req), .m1_addr_i(32'h0000_2000), .m1_we_i(1'b0), .m1_be_i(4'hF), .m1_wdata_i(32'd0),
    .m1_gnt_o(f_m1_gnt), .m1_rvalid_o(f_m1_rvalid), .m1_rdata_o(f_m1_rdata), .m1_err_o(f_m1_err),
    .slv_req_o(f_slv_req), .slv_addr_o(f_slv_addr), .slv_we_o(f_slv_we), .slv_be_o(f_slv_be), .slv_wdata_o(f_slv_wdata),
    .slv_gnt_i(f_gnt), .slv_rvalid_i(f_rvalid), .slv_rdata_i(32'd0), .slv_err_i(1'b0),
    .proto_err_o(f_proto_err), .busy_o(f_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of outstanding master IDs, last granted master,
  // master held by a pending request, sticky protocol error.
  int q[$];
  int last_m;
  int held;
  bit perr;
  bit e_req, e_hs;
  int e_pick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0; slv_gnt = 1'b0; slv_rvalid = 1'b0; slv_err = 1'b0;
    slv_rdata = 32'd0;
    m0_addr = 32'h0000_0A00; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h1111_0000;
    m1_addr = 32'h0000_0B00; m1_we = 1'b1; m1_be = 4'h3; m1_wdata = 32'h2222_0000;
    f_m0_req = 1'b0; f_m1_req = 1'b0; f_gnt = 1'b0; f_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; slv_gnt = 1'b1; slv_rvalid = 1'b1;
    #2;
    check("rst_slv_req", slv_req, 0);
    check("rst_gnt", {m0_gnt, m1_gnt}, 0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_addr_m0", slv_addr, m0_addr);
    @(posedge clk);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    q.delete(); last_m = 1; held = -1; perr = 1'b0;
  endtask

  task automatic eval_check();
    int pick;
    int head;
    bit room, pop;
    #2;
    if (held >= 0) pick = held;
    else if (m0_req && m1_req) pick = 1 - last_m;
    else if (m1_req) pick = 1;
    else pick = 0;
    room   = (q.size() < DEPTH) || (q.size() == DEPTH && slv_rvalid);
    e_pick = pick;
    e_req  = ((pick == 0) ? m0_req : m1_req) && room;
    e_hs   = e_req && slv_gnt;
    pop    = slv_rvalid && (q.size() > 0);
    head   = (q.size() > 0) ? q[0] : -1;
    check("slv_req", slv_req, e_req);
    if (e_req) begin
      check("slv_addr", slv_addr, (pick == 0) ? m0_addr : m1_addr);
      check("slv_we_be", {slv_we, slv_be}, (pick == 0) ? {m0_we, m0_be} : {m1_we, m1_be});
      check("slv_wdata", slv_wdata, (pick == 0) ? m0_wdata : m1_wdata);
    end
    check("m0_gnt", m0_gnt, e_hs && pick == 0);
    check("m1_gnt", m1_gnt, e_hs && pick == 1);
    check("m0_rvalid", m0_rvalid, pop && head == 0);
    check("m1_rvalid", m1_rvalid, pop && head == 1);
    check("m0_err", m0_err, pop && head == 0 && slv_err);
    check("m1_err", m1_err, pop && head == 1 && slv_err);
    check("m0_rdata", m0_rdata, slv_rdata);
    check("m1_rdata", m1_rdata, slv_rdata);
    check("proto_err", proto_err, perr);
    check("busy", busy, (q.size() > 0) || e_req);
  endtask

  task automatic advance();
    @(posedge clk);
    if (slv_rvalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else perr = 1'b1;
    end
    if (e_hs) begin
      q.push_back(e_pick);
      last_m = e_pick;
      held = -1;
    end else if (e_req) begin
      held = e_pick;
    end
    #1;
  endtask

  task automatic step();
    eval_check();
    advance();
  endtask

  initial begin
    bit g0, g1;
    idle_inputs();
    do_reset();

    // Round-robin alternation with both masters requesting.
    m0_req = 1'b1; m1_req = 1'b1; slv_gnt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      slv_rvalid = (c > 0);
      eval_check();
      check("rr_m0_gnt", m0_gnt, (c % 2) == 0);
      check("rr_m1_gnt", m1_gnt, (c % 2) == 1);
      advance();
    end

    // Lock holds m1 while the slave stalls and m0 joins.
    do_reset();
    m1_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      slv_gnt = (c >= 3);
      m0_req  = (c >= 1);
      if (c == 4) m1_req = 1'b0;
      eval_check();
      check("lock_addr", slv_addr, (c < 4) ? m1_addr : m0_addr);
      check("lock_m1_gnt", m1_gnt, c == 3);
      advance();
    end

    // Full FIFO stall, simultaneous pop+push, in-order response steering.
    do_reset();
    slv_gnt = 1'b1;
    m0_req = 1'b1; step();
    m0_req = 1'b0; m1_req = 1'b1; step();
    m1_req = 1'b0; m0_req = 1'b1;
    eval_check();
    check("full_stall_req", slv_req, 0);
    check("full_stall_gnt", {m0_gnt, m1_gnt}, 0);
    check("full_busy", busy, 1);
    advance();
    slv_rvalid = 1'b1; slv_rdata = 32'hDEAD_BEEF;
    eval_check();
    check("resp0_m0_rvalid", m0_rvalid, 1);
    check("resp0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("full_push_pop_gnt", m0_gnt, 1);
    advance();
    m0_req = 1'b0; slv_err = 1'b1; slv_rdata = 32'h0BAD_0001;
    eval_check();
    check("resp1_m1_rvalid", m1_rvalid, 1);
    check("resp1_m1_err", m1_err, 1);
    check("resp1_m0_err", m0_err, 0);
    advance();
    slv_err = 1'b0;
    eval_check();
    check("resp2_m0_rvalid", m0_rvalid, 1);
    advance();
    eval_check();
    check("empty_rvalid_drop", {m0_rvalid, m1_rvalid}, 0);
    advance();
    slv_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      eval_check();
      check("proto_err_sticky", proto_err, 1);
      advance();
    end

    // Reset mid-transaction discards the outstanding ID.
    do_reset();
    m0_req = 1'b1; slv_gnt = 1'b1; step();
    do_reset();
    slv_rvalid = 1'b1;
    eval_check();
    check("post_rst_no_rvalid", m0_rvalid, 0);
    advance();
    slv_rvalid = 1'b0;
    eval_check();
    check("post_rst_proto_err", proto_err, 1);
    advance();

    // Fixed priority instance: m0 always wins.
    do_reset();
    f_m0_req = 1'b1; f_m1_req = 1'b1; f_gnt = 1'b1;
    for (int c = 0; c < 8; c++) begin
      f_rvalid = (c > 0);
      #2;
      check("fixed_m0_gnt", f_m0_gnt, 1);
      check("fixed_m1_gnt", f_m1_gnt, 0);
      @(posedge clk);
      #1;
    end

    // Randomized traffic with well-behaved masters.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 599) do_reset();
      slv_gnt    = ($urandom_range(0, 3) != 0);
      slv_rvalid = (q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) == 0);
      slv_err    = ($urandom_range(0, 7) == 0);
      slv_rdata  = $urandom;
      eval_check();
      g0 = e_hs && e_pick == 0;
      g1 = e_hs && e_pick == 1;
      advance();
      if (g0 || !m0_req) begin
        m0_req = ($urandom_range(0, 9) < 6);
        m0_addr = $urandom; m0_we = 1'($urandom); m0_be = 4'($urandom); m0_wdata = $urandom;
      end
      if (g1 || !m1_req) begin
        m1_req = ($urandom_range(0, 9) < 6);
        m1_addr = $urandom; m1_we = 1'($urandom); m1_be = 4'($urandom); m1_wdata = $urandom;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_praterv_arbiter.md
RISCV_PRATERV_ARBITER -- requirements
Module: riscv_praterv_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with m0 highest.
REQ-002 SHALL have parameter OUTST_DEPTH, default 2, meaning maximum outstanding granted transactions; legal range 1..4.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_req_i / m1_req_i  input  1 each  master request, m0 = core data side after protection unit, m1 = secondary requester.
REQ-006 SHALL have ports mX_addr_i  input  32, mX_we_i  input  1, mX_be_i  input  4, mX_wdata_i  input  32  per-master request payload.
REQ-007 SHALL have ports mX_gnt_o  output  1, mX_rvalid_o  output  1, mX_rdata_o  output  32, mX_err_o  output  1  per-master response.
REQ-008 SHALL have ports slv_req_o  output  1, slv_addr_o  output  32, slv_we_o  output  1, slv_be_o  output  4, slv_wdata_o  output  32  data memory request.
REQ-009 SHALL have ports slv_gnt_i  input  1, slv_rvalid_i  input  1, slv_rdata_i  input  32, slv_err_i  input  1  data memory response.
REQ-010 SHALL have port proto_err_o  output  1  sticky flag: rvalid received with no outstanding transaction.
REQ-011 SHALL have port busy_o  output  1  high while any transaction is outstanding or slv_req_o is high.

Function
REQ-012 SHALL assert slv_req_o combinationally when the selected master requests and the ID FIFO can accept (count < OUTST_DEPTH, or count == OUTST_DEPTH with slv_rvalid_i high).
REQ-013 SHALL drive slv_addr/we/be/wdata from the selected master; mX_gnt_o = slv_gnt_i AND slv_req_o AND (master X selected); zero-cycle grant pass-through.
REQ-014 SHALL select: both idle -> none; one requesting -> that one; both -> m0 if RR_EN=0, else the master not granted last.
REQ-015 SHALL hold selection via a lock register: once slv_req_o is high without slv_gnt_i, the same master stays selected until its handshake, even if the other master requests or gains priority.
REQ-016 SHALL update the round-robin last-granted pointer only on a handshake (slv_req_o AND slv_gnt_i); pointer reset value = m1, so m0 wins the first contention.
REQ-017 SHALL push the granted master ID into an in-order FIFO of depth OUTST_DEPTH on each handshake.
REQ-018 SHALL pop the FIFO on slv_rvalid_i and route rvalid, rdata, err to the master at FIFO head only; the other master's rvalid_o/err_o SHALL stay 0.
REQ-019 SHALL perform push and pop in the same cycle when both occur; count unchanged, no data loss, legal also when full.
REQ-020 SHALL pass mX_rdata_o = slv_rdata_i ungated for both masters; only rvalid/err are steered.
REQ-021 SHALL on slv_rvalid_i with empty FIFO: drop the response, set proto_err_o, count stays 0, no mX_rvalid_o.
REQ-022 SHALL respond with latency 0 on the response path: mX_rvalid_o in the same cycle as slv_rvalid_i.
REQ-023 SHALL deassert slv_req_o when the FIFO is full and no pop occurs, with all mX_gnt_o low.
REQ-024 SHALL wrap FIFO read/write pointers modulo OUTST_DEPTH.

Reset
REQ-025 SHALL on rst_n low asynchronously clear FIFO, count, lock, proto_err_o, and set RR pointer to m1.
REQ-026 SHALL hold all outputs 0 during reset except payload muxes, which select m0 and may follow m0 inputs.
REQ-027 SHALL, on reset mid-transaction, discard outstanding IDs; a later slv_rvalid_i then sets proto_err_o.

Verification
REQ-028 SHALL verify: m0 and m1 request together, slv_gnt_i=1, RR_EN=1 -> m0 granted cycle 0, m1 cycle 1, m0 cycle 2 while both held.
REQ-029 SHALL verify: m1 requests, slv_gnt_i=0 for 3 cycles, m0 raises in cycle 1 -> slv_addr_o stays m1_addr_i until m1_gnt_o, then m0.
REQ-030 SHALL verify: OUTST_DEPTH=2, two grants (m0 then m1), no rvalid -> third request stalls; rvalid rdata=0xDEADBEEF -> m0_rvalid_o=1, next rvalid -> m1_rvalid_o=1.
REQ-031 SHALL verify: FIFO full, rvalid and new handshake in the same cycle -> count stays 2, order preserved.
REQ-032 SHALL verify: slv_rvalid_i with empty FIFO -> proto_err_o=1 sticky until rst_n; slv_err_i=1 on m1's response -> m1_err_o=1, m0_err_o=0.
REQ-033 SHALL verify: RR_EN=0, both requesting continuously -> m0 granted every cycle, m1 never.
